// File: rtl/galaxian_input_ctrl_if.sv
// Input/output bundle for the galaxian input front-end.
// Master drives keyboard/joystick state; slave returns the core-facing words.
interface galaxian_input_ctrl_if;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0;
   logic [15:0] joystick_1;
   logic        rotate;
   logic [6:0]  p1_csjudlr;
   logic [6:0]  p2_csjudlr;
   logic        service;
   logic        busy;

   modport master (
      output ps2_key,
      output joystick_0,
      output joystick_1,
      output rotate,
      input  p1_csjudlr,
      input  p2_csjudlr,
      input  service,
      input  busy
   );

   modport slave (
      input  ps2_key,
      input  joystick_0,
      input  joystick_1,
      input  rotate,
      output p1_csjudlr,
      output p2_csjudlr,
      output service,
      output busy
   );
endinterface

// File: rtl/galaxian_input_ctrl.sv
// PS/2 key decode, joystick merge, orientation remap and a timed
// auto-coin sequencer driving the galaxian P1/P2 CSJUDLR words.
module galaxian_input_ctrl #(
   parameter int COIN_CYCLES  = 2000000,
   parameter int GAP_CYCLES   = 5000000,
   parameter int START_CYCLES = 2000000
) (
   input  logic clk_sys,
   input  logic reset_n,
   galaxian_input_ctrl_if.slave io
);

   localparam int MAX_AB = (COIN_CYCLES > GAP_CYCLES) ?
                           COIN_CYCLES : GAP_CYCLES;
   localparam int MAXC   = (MAX_AB > START_CYCLES) ?
                           MAX_AB : START_CYCLES;
   localparam int CW     = $clog2(MAXC + 1);

   localparam int K_UP    = 0;
   localparam int K_DN    = 1;
   localparam int K_LF    = 2;
   localparam int K_RT    = 3;
   localparam int K_FIRE  = 4;
   localparam int K_ST1   = 5;
   localparam int K_ST2   = 6;
   localparam int K_COIN1 = 7;
   localparam int K_COIN2 = 8;
   localparam int K_P2U   = 9;
   localparam int K_P2D   = 10;
   localparam int K_P2L   = 11;
   localparam int K_P2R   = 12;
   localparam int K_P2F   = 13;
   localparam int K_SVC   = 14;
   localparam int NK      = 15;

   typedef enum logic [2:0] {
      IDLE,
      COIN,
      GAP,
      START,
      RELEASE
   } state_t;

   logic [NK-1:0] keys;
   logic [NK-1:0] hit;
   logic          armed;
   logic          old_toggle;
   logic          key_ev;
   logic [7:0]    code;
   logic          ext0;

   logic [15:0] joy;
   logic        unused_joy;
   logic [3:0]  p1_dir;
   logic [3:0]  p2_dir;
   logic        p1_fire;
   logic        p2_fire;

   state_t  state;
   state_t  state_n;
   logic [CW-1:0] cnt;
   logic    cnt_clr;
   logic    sel2;
   logic    sel2_n;
   logic    req1;
   logic    req2;
   logic    req1_q;
   logic    req2_q;
   logic    rise1;
   logic    rise2;
   logic    seq_coin;
   logic    seq_st1;
   logic    seq_st2;

   logic [6:0] p1_q;
   logic [6:0] p2_q;
   logic       svc_q;

   // No event until the toggle has been sampled once after reset.
   assign key_ev = armed && (io.ps2_key[10] != old_toggle);
   assign code   = io.ps2_key[7:0];
   assign ext0   = !io.ps2_key[8];

   always_comb begin
      hit = '0;
      if (key_ev) begin
         unique case (1'b1)
            code == 8'h75: hit[K_UP] = 1'b1;
            code == 8'h72: hit[K_DN] = 1'b1;
            code == 8'h6B: hit[K_LF] = 1'b1;
            code == 8'h74: hit[K_RT] = 1'b1;
            ext0 && (code == 8'h29 || code == 8'h14):
               hit[K_FIRE] = 1'b1;
            ext0 && (code == 8'h05 || code == 8'h16):
               hit[K_ST1] = 1'b1;
            ext0 && (code == 8'h06 || code == 8'h1E):
               hit[K_ST2] = 1'b1;
            ext0 && code == 8'h2E: hit[K_COIN1] = 1'b1;
            ext0 && code == 8'h36: hit[K_COIN2] = 1'b1;
            ext0 && code == 8'h2D: hit[K_P2U]   = 1'b1;
            ext0 && code == 8'h2B: hit[K_P2D]   = 1'b1;
            ext0 && code == 8'h23: hit[K_P2L]   = 1'b1;
            ext0 && code == 8'h34: hit[K_P2R]   = 1'b1;
            ext0 && code == 8'h1C: hit[K_P2F]   = 1'b1;
            ext0 && code == 8'h2C: hit[K_SVC]   = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         keys       <= '0;
         armed      <= 1'b0;
         old_toggle <= 1'b0;
      end else begin
         armed      <= 1'b1;
         old_toggle <= io.ps2_key[10];
         for (int i = 0; i < NK; i++) begin
            if (hit[i]) keys[i] <= io.ps2_key[9];
         end
      end
   end

   assign joy        = io.joystick_0 | io.joystick_1;
   assign unused_joy = ^joy[15:7];

   // Direction nibble is {up, down, left, right}.
   function automatic logic [3:0] rot(
      input logic [3:0] d,
      input logic       r
   );
      return r ? {d[1], d[0], d[2], d[3]} : d;
   endfunction

   always_comb begin
      p1_dir = rot({keys[K_UP] | joy[3], keys[K_DN] | joy[2],
                    keys[K_LF] | joy[1], keys[K_RT] | joy[0]},
                   io.rotate);
      p2_dir = rot({keys[K_P2U] | joy[3], keys[K_P2D] | joy[2],
                    keys[K_P2L] | joy[1], keys[K_P2R] | joy[0]},
                   io.rotate);
      p1_fire = keys[K_FIRE] | joy[4];
      p2_fire = keys[K_P2F];
   end

   assign req1  = keys[K_ST1] | joy[5];
   assign req2  = keys[K_ST2] | joy[6];
   assign rise1 = req1 & ~req1_q;
   assign rise2 = req2 & ~req2_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         sel2   <= 1'b0;
         req1_q <= 1'b0;
         req2_q <= 1'b0;
      end else begin
         state  <= state_n;
         sel2   <= sel2_n;
         req1_q <= req1;
         req2_q <= req2;
         if (cnt_clr)
            cnt <= '0;
         else if (cnt != {CW{1'b1}})
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_n = state;
      cnt_clr = 1'b0;
      sel2_n  = sel2;
      unique case (state)
         IDLE: begin
            if (rise1 || rise2) begin
               state_n = COIN;
               cnt_clr = 1'b1;
               sel2_n  = !rise1;
            end
         end
         COIN: begin
            if (cnt == CW'(COIN_CYCLES - 1)) begin
               state_n = GAP;
               cnt_clr = 1'b1;
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_CYCLES - 1)) begin
               state_n = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            if (cnt == CW'(START_CYCLES - 1)) begin
               state_n = RELEASE;
               cnt_clr = 1'b1;
            end
         end
         RELEASE: begin
            if (!req1 && !req2) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign seq_coin = (state == COIN);
   assign seq_st1  = (state == START) && !sel2;
   assign seq_st2  = (state == START) && sel2;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         p1_q  <= '0;
         p2_q  <= '0;
         svc_q <= 1'b0;
      end else begin
         p1_q  <= {seq_coin | keys[K_COIN1], seq_st1,
                   p1_fire, p1_dir};
         p2_q  <= {keys[K_COIN2], seq_st2, p2_fire, p2_dir};
         svc_q <= keys[K_SVC];
      end
   end

   assign io.p1_csjudlr = p1_q;
   assign io.p2_csjudlr = p2_q;
   assign io.service    = svc_q;
   assign io.busy       = (state != IDLE);

endmodule

// File: tb/tb_galaxian_input_ctrl.sv
// Scoreboard bench for galaxian_input_ctrl with short sequencer timings.
// Expected sequencer traces are queued at drive time and popped per cycle.
module tb_galaxian_input_ctrl;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   // Entry layout {p1 coin, p1 start, p2 start, busy}.
   logic [3:0] sb_q[$];

   galaxian_input_ctrl_if io();

   galaxian_input_ctrl #(
      .COIN_CYCLES (4),
      .GAP_CYCLES  (3),
      .START_CYCLES(5)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .io     (io)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_key(input logic pr, input logic ext,
                           input logic [7:0] code);
      io.ps2_key = {~io.ps2_key[10], pr, ext, code};
   endtask

   function automatic logic [3:0] obs_seq();
      return {io.p1_csjudlr[6], io.p1_csjudlr[5],
              io.p2_csjudlr[5], io.busy};
   endfunction

   task automatic push_seq(input logic p2);
      sb_q.push_back(4'b0001);
      repeat (4) sb_q.push_back(4'b1001);
      repeat (3) sb_q.push_back(4'b0001);
      repeat (5) sb_q.push_back(p2 ? 4'b0011 : 4'b0101);
   endtask

   task automatic test_reset();
      io.ps2_key    = {1'b1, 1'b1, 1'b1, 8'h75};
      io.joystick_0 = '0;
      io.joystick_1 = '0;
      io.rotate     = 1'b0;
      repeat (2) tick();
      checks++;
      if ({io.p1_csjudlr, io.p2_csjudlr, io.service, io.busy} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got p1=%b p2=%b svc=%b busy=%b want 0",
                  io.p1_csjudlr, io.p2_csjudlr, io.service, io.busy);
      end
      reset_n = 1'b1;
      repeat (3) tick();
      checks++;
      if ({io.p1_csjudlr, io.p2_csjudlr, io.service, io.busy} !== '0) begin
         errors++;
         $display("FAIL reset_release: got p1=%b p2=%b svc=%b busy=%b want 0",
                  io.p1_csjudlr, io.p2_csjudlr, io.service, io.busy);
      end
   endtask

   task automatic test_key();
      send_key(1'b1, 1'b1, 8'h75);
      tick();
      checks++;
      if (io.p1_csjudlr[3] !== 1'b0) begin
         errors++;
         $display("FAIL key_latency: got up=%b want 0", io.p1_csjudlr[3]);
      end
      tick();
      checks++;
      if (io.p1_csjudlr[3] !== 1'b1) begin
         errors++;
         $display("FAIL key_press: got up=%b want 1", io.p1_csjudlr[3]);
      end
      send_key(1'b0, 1'b1, 8'h75);
      repeat (2) tick();
      checks++;
      if (io.p1_csjudlr[3] !== 1'b0) begin
         errors++;
         $display("FAIL key_release: got up=%b want 0", io.p1_csjudlr[3]);
      end
      send_key(1'b1, 1'b0, 8'h2C);
      repeat (2) tick();
      checks++;
      if (io.service !== 1'b1) begin
         errors++;
         $display("FAIL service_key: got %b want 1", io.service);
      end
      send_key(1'b0, 1'b0, 8'h2C);
      repeat (2) tick();
   endtask

   task automatic test_autocoin();
      logic [3:0] exp;
      io.joystick_0[5] = 1'b1;
      push_seq(1'b0);
      repeat (3) sb_q.push_back(4'b0001);
      while (sb_q.size() > 0) begin
         tick();
         exp = sb_q.pop_front();
         checks++;
         if (obs_seq() !== exp) begin
            errors++;
            $display("FAIL autocoin: got %b want %b", obs_seq(), exp);
         end
      end
      io.joystick_0[5] = 1'b0;
      sb_q.push_back(4'b0000);
      while (sb_q.size() > 0) begin
         tick();
         exp = sb_q.pop_front();
         checks++;
         if (obs_seq() !== exp) begin
            errors++;
            $display("FAIL autocoin_idle: got %b want %b", obs_seq(), exp);
         end
      end
   endtask

   task automatic test_both_start();
      logic [3:0] exp;
      int i;
      io.joystick_0[5] = 1'b1;
      io.joystick_1[6] = 1'b1;
      push_seq(1'b0);
      repeat (2) sb_q.push_back(4'b0001);
      i = 0;
      while (sb_q.size() > 0) begin
         tick();
         exp = sb_q.pop_front();
         checks++;
         if (obs_seq() !== exp) begin
            errors++;
            $display("FAIL both_start cyc %0d: got %b want %b",
                     i, obs_seq(), exp);
         end
         if (i == 2) io.joystick_1[6] = 1'b0;
         if (i == 6) io.joystick_1[6] = 1'b1;
         i++;
      end
      io.joystick_0[5] = 1'b0;
      io.joystick_1[6] = 1'b0;
      repeat (4) sb_q.push_back(4'b0000);
      while (sb_q.size() > 0) begin
         tick();
         exp = sb_q.pop_front();
         checks++;
         if (obs_seq() !== exp) begin
            errors++;
            $display("FAIL both_no_requeue: got %b want %b", obs_seq(), exp);
         end
      end
   endtask

   task automatic test_rotate();
      io.joystick_0[1] = 1'b1;
      io.rotate        = 1'b1;
      repeat (2) tick();
      checks++;
      if ({io.p1_csjudlr[3:0], io.p2_csjudlr[3:0]} !== 8'b1000_1000) begin
         errors++;
         $display("FAIL rotate_on: got p1=%b p2=%b want 1000 1000",
                  io.p1_csjudlr[3:0], io.p2_csjudlr[3:0]);
      end
      io.rotate = 1'b0;
      repeat (2) tick();
      checks++;
      if (io.p1_csjudlr[3:0] !== 4'b0010) begin
         errors++;
         $display("FAIL rotate_off: got %b want 0010", io.p1_csjudlr[3:0]);
      end
      io.joystick_0[1] = 1'b0;
      io.joystick_1[0] = 1'b1;
      io.rotate        = 1'b1;
      repeat (2) tick();
      checks++;
      if (io.p1_csjudlr[3:0] !== 4'b0100) begin
         errors++;
         $display("FAIL rotate_right: got %b want 0100", io.p1_csjudlr[3:0]);
      end
      io.joystick_1[0] = 1'b0;
      io.rotate        = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_coin_key();
      send_key(1'b1, 1'b1, 8'h2E);
      repeat (2) tick();
      checks++;
      if (io.p1_csjudlr[6] !== 1'b0) begin
         errors++;
         $display("FAIL coin_ext_ignored: got %b want 0", io.p1_csjudlr[6]);
      end
      send_key(1'b1, 1'b0, 8'h2E);
      repeat (2) tick();
      checks++;
      if ({io.p1_csjudlr[6], io.busy} !== 2'b10) begin
         errors++;
         $display("FAIL coin_key_held: got coin=%b busy=%b want 1 0",
                  io.p1_csjudlr[6], io.busy);
      end
      send_key(1'b0, 1'b0, 8'h2E);
      repeat (2) tick();
      checks++;
      if (io.p1_csjudlr[6] !== 1'b0) begin
         errors++;
         $display("FAIL coin_key_release: got %b want 0", io.p1_csjudlr[6]);
      end
      send_key(1'b1, 1'b0, 8'h36);
      repeat (2) tick();
      checks++;
      if ({io.p2_csjudlr[6], io.p1_csjudlr[6]} !== 2'b10) begin
         errors++;
         $display("FAIL coin2_key: got p2=%b p1=%b want 1 0",
                  io.p2_csjudlr[6], io.p1_csjudlr[6]);
      end
      send_key(1'b0, 1'b0, 8'h36);
      repeat (2) tick();
   endtask

   task automatic test_reset_mid();
      io.joystick_0[5] = 1'b1;
      repeat (3) tick();
      checks++;
      if ({io.p1_csjudlr[6], io.busy} !== 2'b11) begin
         errors++;
         $display("FAIL mid_coin: got coin=%b busy=%b want 1 1",
                  io.p1_csjudlr[6], io.busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({io.p1_csjudlr, io.p2_csjudlr, io.busy} !== '0) begin
         errors++;
         $display("FAIL async_reset: got p1=%b p2=%b busy=%b want 0",
                  io.p1_csjudlr, io.p2_csjudlr, io.busy);
      end
      io.joystick_0[5] = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (6) tick();
      checks++;
      if ({io.p1_csjudlr, io.p2_csjudlr, io.busy} !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got p1=%b p2=%b busy=%b want 0",
                  io.p1_csjudlr, io.p2_csjudlr, io.busy);
      end
   endtask

   initial begin
      test_reset();
      test_key();
      test_autocoin();
      test_both_start();
      test_rotate();
      test_coin_key();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/galaxian_input_ctrl.md
Name: galaxian_input_ctrl

Overview:
Input front-end feeding the galaxian core's P1_CSJUDLR/P2_CSJUDLR/I_SERVICE inputs. Decodes hps_io ps2_key toggle events into held key states and merges them with the joystick_0/1 words. Applies orientation rotation. Replaces the combinational "coin = start" shortcut with a timed auto-coin sequencer: a start-button press produces a coin pulse, a gap, then a start pulse.

Parameters:
COIN_CYCLES, 2000000, clk_sys cycles the coin output is asserted per auto-coin (about 40 ms at 48 MHz).
GAP_CYCLES, 5000000, clk_sys cycles between coin deassert and start assert.
START_CYCLES, 2000000, clk_sys cycles the start output is asserted by the sequencer.

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
joystick_0  in  16  bit0 R, 1 L, 2 D, 3 U, 4 fire, 5 start1, 6 start2.
joystick_1  in  16  same layout; OR'd with joystick_0.
rotate  in  1  1 = horizontal orientation (remap directions).
p1_csjudlr  out  7  {coin, start, fire, up, down, left, right}, player 1.
p2_csjudlr  out  7  same layout, player 2.
service  out  1  service/test key state.
busy  out  1  high while the auto-coin sequencer is not IDLE.

Behaviour:
- Reset: all key-state registers, outputs, busy and the cycle counter are 0. FSM is IDLE. The old_toggle register loads ps2_key[10] on the first clock after reset is released, so no event is seen at release.
- Key decode: an event fires when ps2_key[10] != old_toggle. On an event, the key state for the matched code is loaded with ps2_key[9]. Unmatched codes are ignored.
- Arrow keys ignore bit 8: x75 up, x72 down, x6B left, x74 right. All other keys require bit 8 = 0: 029 and 014 fire; 005 and 016 start1; 006 and 01E start2; 02E coin1; 036 coin2; 02D/02B/023/034 P2 up/down/left/right; 01C P2 fire; 02C service.
- Latency: a toggle present before edge N updates the key state at edge N. The registered output reflects it at edge N+1.
- Direction merge, before rotation: up = key | joy[3], down = key | joy[2], left = key | joy[1], right = key | joy[0]. P1 uses the P1 keys; P2 uses the P2 keys. Both players OR in the same joystick word.
- Rotation (rotate = 1): out_up = in_left, out_down = in_right, out_left = in_down, out_right = in_up. The rotation is purely combinational ahead of the output register.
- Fire: P1 fire = key | joy[4]. P2 fire = P2 key only.
- Auto-coin FSM. start_req1 = start1 key | joy[5]; start_req2 = start2 key | joy[6]. Rising edges are detected against a registered copy.
  - IDLE: on a rise of req1, latch sel = 1. Else on a rise of req2, latch sel = 2. Clear the counter and go to COIN. If both rise in the same cycle, sel = 1.
  - COIN: seq_coin = 1 for exactly COIN_CYCLES cycles, then clear the counter and go to GAP.
  - GAP: GAP_CYCLES cycles with nothing asserted, then go to START.
  - START: seq_start[sel] = 1 for exactly START_CYCLES cycles, regardless of whether the button is released. Then go to RELEASE.
  - RELEASE: wait until req1 = 0 and req2 = 0, then go to IDLE.
  - Rises during a non-IDLE state are ignored and not queued.
- busy = 1 in every state except IDLE.
- The counter is wide enough for the largest parameter and saturates. It never wraps.
- Outputs:
  - P1 coin = seq_coin | coin1 key.
  - P2 coin = coin2 key.
  - P1 start = seq_start[1].
  - P2 start = seq_start[2].
  - Direct start keys do NOT drive the start outputs; they only request the sequencer.
- service = service key state.
- reset_n asserted mid-sequence: immediate return to IDLE with all outputs 0. No pulse completes.

Test Plan:
(Use COIN_CYCLES = 4, GAP_CYCLES = 3, START_CYCLES = 5.)
1. Release reset with ps2_key[10] = 1 -> no key state changes and all outputs 0. Then toggle [10] with {pressed = 1, ext = 1, code 75} -> p1_csjudlr[3] = 1 one edge after the state update. Toggle with pressed = 0 -> it returns to 0.
2. Set joy[5] = 1 and hold it -> coin = 1 for exactly 4 cycles, 0 for 3, then P1 start = 1 for exactly 5. busy stays 1 until joy[5] = 0, then busy = 0 one edge later.
3. Raise joy[5] and joy[6] on the same cycle -> only P1 start pulses. Raise joy[6] again during GAP -> ignored, no second sequence.
4. rotate = 1 with joy[1] (left) -> output up = 1 and left = 0. With rotate = 0 -> output left = 1.
5. Send scancode 02E with ext = 1 -> ignored. With ext = 0 and pressed -> P1 coin = 1 while held, sequencer stays IDLE.
6. Assert reset_n = 0 during COIN -> coin = 0 and busy = 0 immediately (asynchronous). After release with no start held, the FSM stays IDLE.
